// File: rtl/muldiv_unit_if.sv
// Issue/result handshake bundle for muldiv_unit: operation request channel and result channel.
interface muldiv_unit_if #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_funct3;
  logic             in_width_32;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_funct3, in_width_32, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  modport slave (
    input  in_valid, in_funct3, in_width_32, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle RV64M multiply/divide unit: restoring divider and shift-add multiplier on magnitudes.
// Optional MULDIV_FAST_MUL_EN replaces the iterative multiply with a single registered multiplier.
module muldiv_unit #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned TAG_W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  output logic         busy,
  muldiv_unit_if.slave bus
);
  localparam int unsigned PW    = 2 * XLEN;
  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam int unsigned W_SH  = XLEN - 32;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]    acc_q, acc_d, lo_q, lo_d, opd_q, opd_d;
  logic [2:0]         f3_q, f3_d;
  logic               w32_q, w32_d, sa_q, sa_d, sb_q, sb_d;
  logic [XLEN-1:0]    out_result_q, out_result_d;
  logic [TAG_W-1:0]   out_tag_q, out_tag_d;
  logic               out_valid_q, in_ready_q, busy_q;

  logic               is_div_c, sa_en_c, sb_en_c, sign_a_c, sign_b_c;
  logic               illegal_c, b_zero_c, ovf_c, accept_c;
  logic [XLEN-1:0]    a_ext_c, b_ext_c, mag_a_c, mag_b_c;
  logic [XLEN:0]      mul_sum_c, div_sh_c, div_diff_c;
  logic               div_ge_c;
  logic [XLEN-1:0]    step_acc_c, step_lo_c;
  logic [PW-1:0]      iter_prod_c;
  logic [CNT_W-1:0]   last_c;

  function automatic logic [XLEN-1:0] sext_w(input logic w, input logic [XLEN-1:0] v);
    return w ? XLEN'($signed(v[31:0])) : v;
  endfunction

  function automatic logic [XLEN-1:0] mul_fmt(input logic [2:0] f, input logic w,
                                              input logic neg, input logic [PW-1:0] mag);
    logic [PW-1:0] p;
    p = neg ? -mag : mag;
    return sext_w(w, (f == F_MUL) ? p[XLEN-1:0] : p[PW-1:XLEN]);
  endfunction

  function automatic logic [XLEN-1:0] div_fmt(input logic [2:0] f, input logic w, input logic sa,
                                              input logic sb, input logic [XLEN-1:0] quo,
                                              input logic [XLEN-1:0] rem);
    logic [XLEN-1:0] q, r;
    q = (sa ^ sb) ? -quo : quo;
    r = sa ? -rem : rem;
    return sext_w(w, f[1] ? r : q);
  endfunction

  // Operand decode: extension, magnitudes and special-case detection on the offered op
  always_comb begin
    is_div_c = bus.in_funct3[2];
    sa_en_c  = is_div_c ? !bus.in_funct3[0]
                        : (bus.in_funct3 == F_MULH) || (bus.in_funct3 == F_MULHSU);
    sb_en_c  = is_div_c ? !bus.in_funct3[0] : (bus.in_funct3 == F_MULH);
    a_ext_c  = bus.in_a;
    b_ext_c  = bus.in_b;
    if (bus.in_width_32) begin
      a_ext_c = sa_en_c ? XLEN'($signed(bus.in_a[31:0])) : XLEN'(bus.in_a[31:0]);
      b_ext_c = sb_en_c ? XLEN'($signed(bus.in_b[31:0])) : XLEN'(bus.in_b[31:0]);
    end
    sign_a_c  = sa_en_c & a_ext_c[XLEN-1];
    sign_b_c  = sb_en_c & b_ext_c[XLEN-1];
    mag_a_c   = sign_a_c ? -a_ext_c : a_ext_c;
    mag_b_c   = sign_b_c ? -b_ext_c : b_ext_c;
    illegal_c = bus.in_width_32 && !is_div_c && (bus.in_funct3 != F_MUL);
    b_zero_c  = (b_ext_c == '0);
    ovf_c     = is_div_c && sa_en_c &&
                (bus.in_width_32 ? (bus.in_a[31:0] == 32'h8000_0000 && bus.in_b[31:0] == '1)
                                 : (bus.in_a == {1'b1, {(XLEN-1){1'b0}}} && bus.in_b == '1));
    accept_c  = (state_q == S_IDLE) && bus.in_valid && !flush;
  end

  // One iteration of the shared engine: restoring divide step or shift-add multiply step
  always_comb begin
    mul_sum_c  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
    div_sh_c   = {acc_q, lo_q[XLEN-1]};
    div_ge_c   = (div_sh_c >= {1'b0, opd_q});
    div_diff_c = div_sh_c - {1'b0, opd_q};
    if (f3_q[2]) begin
      step_acc_c = div_ge_c ? XLEN'(div_diff_c) : XLEN'(div_sh_c);
      step_lo_c  = {lo_q[XLEN-2:0], div_ge_c};
    end else begin
      step_acc_c = mul_sum_c[XLEN:1];
      step_lo_c  = {mul_sum_c[0], lo_q[XLEN-1:1]};
    end
    // A -W multiply stops XLEN-32 shifts early, so realign the product
    iter_prod_c = w32_q ? ({step_acc_c, step_lo_c} >> W_SH) : {step_acc_c, step_lo_c};
    last_c      = w32_q ? CNT_W'(31) : CNT_W'(XLEN - 1);
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    lo_d         = lo_q;
    opd_d        = opd_q;
    f3_d         = f3_q;
    w32_d        = w32_q;
    sa_d         = sa_q;
    sb_d         = sb_q;
    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          f3_d      = bus.in_funct3;
          w32_d     = bus.in_width_32;
          sa_d      = sign_a_c;
          sb_d      = sign_b_c;
          out_tag_d = bus.in_tag;
          cnt_d     = '0;
          if (illegal_c) begin
            out_result_d = '0;
            state_d      = S_DONE;
          end else if (is_div_c && (b_zero_c || ovf_c)) begin
            if (bus.in_funct3[1])
              out_result_d = sext_w(bus.in_width_32, ovf_c ? '0 : a_ext_c);
            else
              out_result_d = sext_w(bus.in_width_32, ovf_c ? a_ext_c : '1);
            state_d = S_DONE;
          end else if (is_div_c) begin
            acc_d   = '0;
            lo_d    = bus.in_width_32 ? (mag_a_c << W_SH) : mag_a_c;
            opd_d   = mag_b_c;
            state_d = S_BUSY;
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            out_result_d = mul_fmt(bus.in_funct3, bus.in_width_32, sign_a_c ^ sign_b_c,
                                   PW'(mag_a_c) * PW'(mag_b_c));
            state_d      = S_DONE;
`else
            acc_d   = '0;
            lo_d    = mag_a_c;
            opd_d   = mag_b_c;
            state_d = S_BUSY;
`endif
          end
        end
      end
      S_BUSY: begin
        acc_d = step_acc_c;
        lo_d  = step_lo_c;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == last_c) begin
          cnt_d   = '0;
          state_d = S_DONE;
          out_result_d = f3_q[2] ? div_fmt(f3_q, w32_q, sa_q, sb_q, step_lo_c, step_acc_c)
                                 : mul_fmt(f3_q, w32_q, sa_q ^ sb_q, iter_prod_c);
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      acc_q        <= '0;
      lo_q         <= '0;
      opd_q        <= '0;
      f3_q         <= '0;
      w32_q        <= 1'b0;
      sa_q         <= 1'b0;
      sb_q         <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      lo_q         <= lo_d;
      opd_q        <= opd_d;
      f3_q         <= f3_d;
      w32_q        <= w32_d;
      sa_q         <= sa_d;
      sb_q         <= sb_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
      out_valid_q  <= (state_d == S_DONE);
      in_ready_q   <= (state_d == S_IDLE);
      busy_q       <= (state_d != S_IDLE);
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && accept_c && illegal_c)
      $error("muldiv_unit: -W form of MULH/MULHSU/MULHU is illegal");
  end
`endif

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_tag    = out_tag_q;
  assign busy           = busy_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed + random scoreboard bench for muldiv_unit (XLEN = 64); honours MULDIV_FAST_MUL_EN.
module tb_muldiv_unit;
  localparam int unsigned XLEN  = 64;
  localparam int unsigned TAG_W = 5;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT  = 1;
  localparam int MULW_LAT = 1;
`else
  localparam int MUL_LAT  = 65;
  localparam int MULW_LAT = 33;
`endif
  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  logic clk = 1'b0;
  logic reset, flush, busy;

  muldiv_unit_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();
  muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .busy(busy), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  tag;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Reference model of RV64M semantics
  function automatic logic [63:0] ref_op(input logic [2:0] f, input logic w,
                                         input logic [63:0] a, input logic [63:0] b);
    logic [127:0]       pa, pb, p;
    logic signed [63:0] s_a, s_b;
    logic signed [31:0] s_a32, s_b32;
    logic [31:0]        a32, b32, r32;
    logic [63:0]        r;
    s_a = a; s_b = b; a32 = a[31:0]; b32 = b[31:0]; s_a32 = a32; s_b32 = b32;
    r32 = '0; r = '0;
    if (w) begin
      case (f)
        MUL: r32 = a32 * b32;
        DIV, REM: begin
          if (b32 == 0)                                   r32 = (f == DIV) ? 32'hFFFF_FFFF : a32;
          else if (a32 == 32'h8000_0000 && b32 == '1)     r32 = (f == DIV) ? a32 : 32'h0;
          else if (f == DIV)                              r32 = s_a32 / s_b32;
          else                                            r32 = s_a32 % s_b32;
        end
        DIVU, REMU: begin
          if (b32 == 0)        r32 = (f == DIVU) ? 32'hFFFF_FFFF : a32;
          else if (f == DIVU)  r32 = a32 / b32;
          else                 r32 = a32 % b32;
        end
        default: r32 = '0;
      endcase
      r = {{32{r32[31]}}, r32};
    end else begin
      case (f)
        MUL: r = a * b;
        MULH, MULHSU, MULHU: begin
          pa = (f != MULHU) ? {{64{a[63]}}, a} : {64'h0, a};
          pb = (f == MULH)  ? {{64{b[63]}}, b} : {64'h0, b};
          p  = pa * pb;
          r  = p[127:64];
        end
        DIV, REM: begin
          if (b == 0)                      r = (f == DIV) ? ONES : a;
          else if (a == MINV && b == ONES) r = (f == DIV) ? a : 64'h0;
          else if (f == DIV)               r = s_a / s_b;
          else                             r = s_a % s_b;
        end
        default: begin
          if (b == 0)          r = (f == DIVU) ? ONES : a;
          else if (f == DIVU)  r = a / b;
          else                 r = a % b;
        end
      endcase
    end
    return r;
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
    logic bz, ov;
    if (!f[2]) return w ? MULW_LAT : MUL_LAT;
    bz = w ? (b[31:0] == 0) : (b == 0);
    ov = !f[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == '1) : (a == MINV && b == ONES));
    if (bz || ov) return 1;
    return w ? 33 : 65;
  endfunction

  // Offer one op at a negedge; accepted at the following posedge (edge k)
  task automatic issue(input logic [2:0] f, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] tag, input logic [63:0] res,
                       input int lat);
    exp_t e;
    check("in_ready_before_issue", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1; bus.in_funct3 = f; bus.in_width_32 = w;
    bus.in_a = a; bus.in_b = b; bus.in_tag = tag;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    e.res = res; e.tag = tag; e.lat = lat;
    sb_q.push_back(e);
  endtask

  // Wait (bounded) for the result, compare, optionally stall, then retire
  task automatic collect(input string name, input int hold);
    exp_t e;
    int   n;
    n = 1;
    @(negedge clk);
    while (bus.out_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    e = sb_q.pop_front();
    check({name, "_latency"}, 64'(n), 64'(e.lat));
    check({name, "_result"}, bus.out_result, e.res);
    check({name, "_tag"}, 64'(bus.out_tag), 64'(e.tag));
    check({name, "_in_ready_done"}, 64'(bus.in_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
      check({name, "_hold_result"}, bus.out_result, e.res);
      check({name, "_hold_tag"}, 64'(bus.out_tag), 64'(e.tag));
      check({name, "_hold_in_ready"}, 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    check({name, "_idle_in_ready"}, 64'(bus.in_ready), 64'd1);
    check({name, "_idle_valid"}, 64'(bus.out_valid), 64'd0);
    check({name, "_idle_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic run(input string name, input logic [2:0] f, input logic w,
                     input logic [63:0] a, input logic [63:0] b, input logic [4:0] tag,
                     input logic [63:0] res, input int lat);
    issue(f, w, a, b, tag, res, lat);
    collect(name, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  rf;
    logic        rw;
    logic [63:0] ra, rb;

    bus.in_valid = 1'b0; bus.in_funct3 = '0; bus.in_width_32 = 1'b0;
    bus.in_a = '0; bus.in_b = '0; bus.in_tag = '0; bus.out_ready = 1'b0;
    flush = 1'b0; reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_result", bus.out_result, 64'd0);
    check("rst_out_tag", 64'(bus.out_tag), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;

    run("div_m7_2",   DIV,  1'b0, -64'sd7, 64'd2, 5'd1, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    run("rem_m7_2",   REM,  1'b0, -64'sd7, 64'd2, 5'd2, ONES, 65);
    run("divu_by0",   DIVU, 1'b0, 64'd5, 64'd0, 5'd3, ONES, 1);
    run("remu_by0",   REMU, 1'b0, 64'd5, 64'd0, 5'd4, 64'd5, 1);
    run("div_ovf",    DIV,  1'b0, MINV, ONES, 5'd5, MINV, 1);
    run("rem_ovf",    REM,  1'b0, MINV, ONES, 5'd6, 64'd0, 1);
    run("mulhu_ones", MULHU, 1'b0, ONES, ONES, 5'd7, 64'hFFFF_FFFF_FFFF_FFFE, MUL_LAT);
    run("mulw",       MUL,  1'b1, 64'h7FFF_FFFF, 64'd2, 5'd8, 64'hFFFF_FFFF_FFFF_FFFE, MULW_LAT);
    run("mulh_m3_5",  MULH, 1'b0, -64'sd3, 64'd5, 5'd9, ONES, MUL_LAT);
    run("mul_m3_5",   MUL,  1'b0, -64'sd3, 64'd5, 5'd10, 64'hFFFF_FFFF_FFFF_FFF1, MUL_LAT);
    run("mulhsu_m1_2", MULHSU, 1'b0, ONES, 64'd2, 5'd11, ONES, MUL_LAT);
    run("divw_ovf",   DIV,  1'b1, 64'h1234_5678_8000_0000, 64'hFFFF_FFFF, 5'd12,
        64'hFFFF_FFFF_8000_0000, 1);
    run("remw_m7_2",  REM,  1'b1, 64'hABCD_0000_FFFF_FFF9, 64'd2, 5'd14, ONES, 33);

    issue(DIVU, 1'b1, 64'h8000_0000, 64'd2, 5'd13, 64'h0000_0000_4000_0000, 33);
    collect("divuw_hold", 5);

    // Flush at cycle k+10 of a divide
    issue(DIV, 1'b0, 64'd1000, 64'd7, 5'd20, 64'd0, 0);
    void'(sb_q.pop_back());
    @(negedge clk);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_in_ready", 64'(bus.in_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      check("flush_no_valid", 64'(bus.out_valid), 64'd0);
      @(negedge clk);
    end
    run("remu_after_flush", REMU, 1'b0, 64'd17, 64'd5, 5'd21, 64'd2, 65);

    // Same sequence with reset
    issue(DIV, 1'b0, 64'd1000, 64'd7, 5'd22, 64'd0, 0);
    void'(sb_q.pop_back());
    @(negedge clk);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_valid", 64'(bus.out_valid), 64'd0);
    check("mrst_result", bus.out_result, 64'd0);
    check("mrst_tag", 64'(bus.out_tag), 64'd0);
    check("mrst_in_ready", 64'(bus.in_ready), 64'd1);
    run("remu_after_reset", REMU, 1'b0, 64'd17, 64'd5, 5'd23, 64'd2, 65);

    // Random legal ops against the reference model
    for (int i = 0; i < 16; i++) begin
      rf = 3'($urandom_range(0, 7));
      rw = 1'($urandom_range(0, 1));
      if (rf inside {MULH, MULHSU, MULHU}) rw = 1'b0;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: rb = '0;
        1: rb = 64'($urandom_range(1, 9));
        2: rb = {32'h0, $urandom} >> $urandom_range(0, 31);
        3: ra = -ra;
        default: ;
      endcase
      issue(rf, rw, ra, rb, 5'(i), ref_op(rf, rw, ra, rb), exp_lat(rf, rw, ra, rb));
      collect("random", 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised, multi-cycle RV64M multiply/divide execution unit for the execute stage, beside the combinational ALU. It accepts one operation at a time over a valid/ready handshake and covers all M-extension funct3 codes, including the 32-bit -W forms. It produces results with RISC-V-exact corner-case semantics and holds each result until downstream accepts it. The ALU keeps single-cycle ops; funct7 = 000_0001 traffic is steered here.

## Interface
- XLEN, 64: datapath width; 32 or 64. The -W forms are legal only when XLEN = 64.
- TAG_W, 5: width of the opaque tag (destination register / ROB id) carried from input to output.

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  kill the in-flight op; any result is dropped
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept an operation
- in_funct3  in  3  M-extension funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
- in_width_32  in  1  -W form: operate on bits [31:0] and sign-extend the result
- in_a  in  XLEN  rs1 operand
- in_b  in  XLEN  rs2 operand
- in_tag  in  TAG_W  tag, returned unchanged on out_tag
- out_valid  out  1  result available
- out_ready  in  1  consumer takes the result
- out_result  out  XLEN  result
- out_tag  out  TAG_W  tag of the result
- busy  out  1  state != IDLE

## Operation
- FSM states:
  - IDLE: in_ready = 1. An operation is accepted when in_valid && in_ready. The operands, funct3, width_32 and tag are registered on acceptance.
  - BUSY: iterative engine runs for N cycles. N = XLEN for full-width ops and 32 for -W ops.
  - DONE: out_valid = 1. Go to IDLE on out_ready.
- in_ready is 1 only in IDLE. The unit does not accept a new op in the same cycle a result retires.
- Division uses radix-2 restoring, one quotient bit per cycle, on operand magnitudes.
  - Signed quotient is negated when the operand signs differ.
  - Signed remainder takes the sign of the dividend.
- Iterative multiply is shift-add, one bit per cycle, and produces the full 2*XLEN-bit product.
  - MUL returns product[XLEN-1:0].
  - MULH, MULHSU and MULHU return product[2*XLEN-1:XLEN], using signed×signed, signed×unsigned and unsigned×unsigned respectively.
- -W ops use a[31:0] and b[31:0]. Signedness follows funct3. Result = {32{r[31]}, r[31:0]}; this includes DIVUW and REMUW.
- Special cases skip BUSY and go straight to DONE (IDLE -> DONE):
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow (most-negative ÷ -1): quotient = dividend; remainder = 0.
  - For -W ops, these checks use the 32-bit operands.
- Illegal op: in_width_32 with MULH, MULHSU or MULHU.
  - result = 0, go straight to DONE.
  - Simulation-only $error is raised.
- flush: any state -> IDLE on the next edge. out_valid = 0 in that next cycle. A flush in IDLE has no effect. flush takes priority over acceptance and retirement in the same cycle.
- reset: state = IDLE, out_valid = 0, out_result = 0, out_tag = 0, busy = 0, counter = 0. Reset mid-operation discards the op.

## Timing
- Acceptance edge is edge k.
- Iterative ops:
  - BUSY during cycles k+1 .. k+N.
  - out_valid first high in cycle k+N+1.
  - Full-width latency = XLEN+1 cycles; -W latency = 33 cycles.
- Special-case and illegal ops: out_valid high in cycle k+1.
- out_result and out_tag are registered. They stay stable while out_valid && !out_ready.
- out_valid never depends combinationally on out_ready. in_ready never depends combinationally on in_valid.
- Back-to-back throughput: at most one op every latency+1 cycles.

## Configuration
- MULDIV_FAST_MUL_EN:
  - Defined: all multiply ops use a single registered XLEN×XLEN multiplier. The FSM goes IDLE -> DONE, so out_valid is high in cycle k+1.
  - Undefined: multiplies use the iterative shift-add engine. Latency matches division (XLEN+1 cycles, or 33 for -W).
- Division is always iterative. Results are bit-identical with and without the macro.

## Test plan
- DIV, a = -7, b = 2 (XLEN = 64) -> out_result 0xFFFF_FFFF_FFFF_FFFD, out_valid in cycle k+65. REM with the same operands -> 0xFFFF_FFFF_FFFF_FFFF.
- DIVU a = 5, b = 0 -> 0xFFFF_FFFF_FFFF_FFFF at k+1. REMU a = 5, b = 0 -> 5. DIV a = 0x8000_0000_0000_0000, b = -1 -> 0x8000_0000_0000_0000; REM with the same operands -> 0.
- MULHU a = b = 0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFE. MULW a = 0x7FFF_FFFF, b = 2 -> 0xFFFF_FFFF_FFFF_FFFE. Check latency both with and without MULDIV_FAST_MUL_EN.
- DIVW a = 0x1234_5678_8000_0000, b = 0xFFFF_FFFF -> 0xFFFF_FFFF_8000_0000 at k+1. DIVUW a = 0x8000_0000, b = 2 -> 0x0000_0000_4000_0000 at k+33.
- Hold out_ready = 0 for 5 cycles after out_valid -> out_result and out_tag stable, in_ready = 0. Raise out_ready -> IDLE in the next cycle.
- Assert flush at k+10 of a DIV -> IDLE at k+11, no out_valid for that tag. A following REMU 17 % 5 -> 2 with its own tag. Repeat the sequence using reset instead of flush.
